// File: rtl/la_rrsel2_if.sv
// Handshake bundle between the two requesters and the la_rrsel2 arbiter.
// The requester side (master) drives en/req/last; the arbiter (slave) returns the grant.
interface la_rrsel2_if;
  // Handshake contract: req[i] is a level that stays high until requester i is served.
  // gnt is one-hot or zero and changes only on a clock edge.
  // While gnt[i] is set, the owner raises last on its final cycle, or drops req[i], to release.
  logic       en;
  logic [1:0] req;
  logic       last;
  logic [1:0] gnt;
  logic       busy;
  logic       tmo;
  logic [1:0] state;  // arbiter FSM state, exposed for checkers

  modport master (output en, req, last, input gnt, busy, tmo, state);
  modport slave  (input en, req, last, output gnt, busy, tmo, state);
endinterface

// File: rtl/la_rrsel2.sv
// Two-requester round-robin arbiter with a registered one-hot grant for an and-or select cell.
// Optional hold-time watchdog enabled by defining LA_RRSEL2_TIMEOUT_EN.
module la_rrsel2 #(
  parameter     PROP    = "DEFAULT",
  parameter int MAXHOLD = 16
) (
  input logic       clk,
  input logic       nreset,
  la_rrsel2_if.slave bus
);

  // State encoding is the grant itself, so gnt comes straight from flops.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0] state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       owner, other;
  logic       timeout;
  logic       rel;

  function automatic logic [1:0] pick(input logic [1:0] r, input logic p);
    logic [1:0] s;
    case (r)
      2'b11:   s = p ? OWN1 : OWN0;
      2'b01:   s = OWN0;
      2'b10:   s = OWN1;
      default: s = IDLE;
    endcase
    return s;
  endfunction

  assign owner = state_q[1];
  assign other = ~owner;

  always_comb begin
    rel     = ~bus.req[owner] | bus.last | timeout;
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.en) state_d = pick(bus.req, ptr_q);
      end
      OWN0, OWN1: begin
        if (rel) begin
          ptr_d   = other;
          state_d = bus.en ? pick(bus.req, other) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt   = state_q;
  assign bus.busy  = |state_q;
  assign bus.state = state_q;

`ifdef LA_RRSEL2_TIMEOUT_EN
  localparam int              CW   = $clog2(MAXHOLD);
  localparam logic [CW-1:0]   CMAX = CW'(MAXHOLD - 1);

  logic [CW-1:0] cnt_q;
  logic          tmo_q;

  // Only a waiting peer can force the owner off; a lone owner may hold forever.
  assign timeout = (state_q != IDLE) && (cnt_q == CMAX) && bus.req[other];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= timeout & bus.req[owner] & ~bus.last;
      if (state_q == IDLE || rel) cnt_q <= '0;
      else if (cnt_q != CMAX)     cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.tmo = tmo_q;
`else
  assign timeout = 1'b0;
  assign bus.tmo = 1'b0;
`endif

endmodule
